// File: rtl/ex_pkg.sv
// Shared encodings, FSM state type and helpers for the MIPS execute stage.
package ex_pkg;

    localparam int MULT_CYCLES_DEF = 32;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_RSVD  = 2'b11;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // Magnitude of a two's-complement word; |0x80000000| still fits unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Bundles the ID/EX inputs, forwarding sources and EX/MEM-side outputs of the execute stage.
interface ex_if;
    logic [31:0] x_pc_plus4;
    logic [31:0] x_read_data1;
    logic [31:0] x_read_data2;
    logic [31:0] x_sign_ext;
    logic [4:0]  x_rs;
    logic [4:0]  x_rt;
    logic [4:0]  x_rd;
    logic [1:0]  x_alu_op;
    logic        x_alu_src;
    logic        x_reg_dst;
    logic        x_addi;
    logic        x_reg_write;
    logic        x_mem_read;
    logic        x_mem_write;

    logic        m_reg_write;
    logic [4:0]  m_rd;
    logic [31:0] m_alu_result;
    logic        w_reg_write;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output x_pc_plus4, x_read_data1, x_read_data2, x_sign_ext,
        output x_rs, x_rt, x_rd, x_alu_op,
        output x_alu_src, x_reg_dst, x_addi, x_reg_write, x_mem_read, x_mem_write,
        output m_reg_write, m_rd, m_alu_result, w_reg_write, w_rd, w_data,
        input  alu_result, zero, branch_target, store_data, write_reg,
        input  ex_reg_write, ex_mem_read, ex_mem_write, stall, hi, lo
    );

    modport slave (
        input  x_pc_plus4, x_read_data1, x_read_data2, x_sign_ext,
        input  x_rs, x_rt, x_rd, x_alu_op,
        input  x_alu_src, x_reg_dst, x_addi, x_reg_write, x_mem_read, x_mem_write,
        input  m_reg_write, m_rd, m_alu_result, w_reg_write, w_rd, w_data,
        output alu_result, zero, branch_target, store_data, write_reg,
        output ex_reg_write, ex_mem_read, ex_mem_write, stall, hi, lo
    );
endinterface

// File: rtl/ex_mult_seq.sv
// Iterative signed shift-add multiplier: magnitudes are multiplied one bit per cycle
// and the sign is applied when the product is committed to HI/LO.
module mult_seq
    import ex_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_CYCLES - 1);

    mult_state_e      state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             last_iter;

    logic [31:0] mcand_p0;
    logic [63:0] prod_p0;
    logic        sign_p0;
    logic [32:0] sum;
    logic [63:0] prod_nxt;
    logic [63:0] prod_neg;

    assign last_iter = (count == LAST_CNT);
    assign busy      = (state == ST_BUSY);
    assign done      = (state == ST_DONE);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_BUSY)
                count <= last_iter ? '0 : count + CNT_W'(1);
            else
                count <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (last_iter) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        sum      = {1'b0, prod_p0[63:32]} + {1'b0, (prod_p0[0] ? mcand_p0 : 32'd0)};
        prod_nxt = {sum, prod_p0[31:1]};
        prod_neg = ~prod_nxt + 64'd1;
    end

    always_ff @(negedge clk) begin
        if (state == ST_IDLE && start) begin
            mcand_p0 <= abs32(op_a);
            prod_p0  <= {32'd0, abs32(op_b)};
            sign_p0  <= op_a[31] ^ op_b[31];
        end else if (state == ST_BUSY) begin
            prod_p0 <= prod_nxt;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_BUSY && last_iter) begin
            {hi, lo} <= sign_p0 ? prod_neg : prod_nxt;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch target, destination select,
// and the multiplier that stalls the front of the pipeline while it runs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic signed [31:0] fwd_a;
    logic signed [31:0] fwd_b;
    logic signed [31:0] alu_b;
    logic signed [31:0] result;
    logic        [5:0]  funct;
    logic        [4:0]  shamt;
    logic               mult_present;
    logic               mult_busy;
    logic               mult_done;
    logic               stall;
    logic        [31:0] hi_q;
    logic        [31:0] lo_q;

    assign funct = bus.x_sign_ext[5:0];
    assign shamt = bus.x_sign_ext[10:6];

    // MEM result is younger than WB data, so it wins when both match.
    always_comb begin
        fwd_a = $signed(bus.x_read_data1);
        if (bus.m_reg_write && bus.m_rd != 5'd0 && bus.m_rd == bus.x_rs)
            fwd_a = $signed(bus.m_alu_result);
        else if (bus.w_reg_write && bus.w_rd != 5'd0 && bus.w_rd == bus.x_rs)
            fwd_a = $signed(bus.w_data);

        fwd_b = $signed(bus.x_read_data2);
        if (bus.m_reg_write && bus.m_rd != 5'd0 && bus.m_rd == bus.x_rt)
            fwd_b = $signed(bus.m_alu_result);
        else if (bus.w_reg_write && bus.w_rd != 5'd0 && bus.w_rd == bus.x_rt)
            fwd_b = $signed(bus.w_data);
    end

    assign alu_b = (bus.x_alu_src || bus.x_addi) ? $signed(bus.x_sign_ext) : fwd_b;

    always_comb begin
        result = '0;
        if (bus.x_addi) begin
            result = fwd_a + alu_b;
        end else begin
            case (bus.x_alu_op)
                ALU_ADD: result = fwd_a + alu_b;
                ALU_SUB: result = fwd_a - alu_b;
                ALU_RTYPE: begin
                    case (funct)
                        F_ADD:  result = fwd_a + alu_b;
                        F_SUB:  result = fwd_a - alu_b;
                        F_AND:  result = fwd_a & alu_b;
                        F_OR:   result = fwd_a | alu_b;
                        F_SLT:  result = (fwd_a < alu_b) ? 32'sd1 : 32'sd0;
                        F_SLL:  result = alu_b << shamt;
                        F_MFHI: result = $signed(hi_q);
                        F_MFLO: result = $signed(lo_q);
                        default: result = '0;
                    endcase
                end
                default: result = '0;
            endcase
        end
    end

    assign mult_present = (bus.x_alu_op == ALU_RTYPE) && !bus.x_addi && (funct == F_MULT);

    mult_seq #(
        .MULT_CYCLES (MULT_CYCLES)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (mult_present),
        .op_a  (fwd_a),
        .op_b  (fwd_b),
        .busy  (mult_busy),
        .done  (mult_done),
        .hi    (hi_q),
        .lo    (lo_q)
    );

    // DONE deliberately leaves stall low so ID/EX advances past the finished mult.
    assign stall = (mult_present && !mult_busy && !mult_done) || mult_busy;

    assign bus.alu_result    = result;
    assign bus.zero          = (result == 32'sd0);
    assign bus.branch_target = bus.x_pc_plus4 + {bus.x_sign_ext[29:0], 2'b00};
    assign bus.store_data    = fwd_b;
    assign bus.write_reg     = bus.x_reg_dst ? bus.x_rd : bus.x_rt;
    assign bus.ex_reg_write  = bus.x_reg_write && !stall && !mult_present;
    assign bus.ex_mem_read   = bus.x_mem_read && !stall;
    assign bus.ex_mem_write  = bus.x_mem_write && !stall;
    assign bus.stall         = stall;
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: forwarding, ALU ops, branch, multiplier timing and reset abort.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_if bus ();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.x_pc_plus4   = '0;
        bus.x_read_data1 = '0;
        bus.x_read_data2 = '0;
        bus.x_sign_ext   = '0;
        bus.x_rs         = '0;
        bus.x_rt         = '0;
        bus.x_rd         = '0;
        bus.x_alu_op     = '0;
        bus.x_alu_src    = 1'b0;
        bus.x_reg_dst    = 1'b0;
        bus.x_addi       = 1'b0;
        bus.x_reg_write  = 1'b0;
        bus.x_mem_read   = 1'b0;
        bus.x_mem_write  = 1'b0;
        bus.m_reg_write  = 1'b0;
        bus.m_rd         = '0;
        bus.m_alu_result = '0;
        bus.w_reg_write  = 1'b0;
        bus.w_rd         = '0;
        bus.w_data       = '0;
    endtask

    // Inputs change just after the negedge (as ID/EX would); outputs are sampled after the posedge.
    task automatic rtype(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #1;
        clear_inputs();
        bus.x_alu_op     = 2'b10;
        bus.x_sign_ext   = {26'd0, funct};
        bus.x_rs         = 5'd1;
        bus.x_rt         = 5'd2;
        bus.x_read_data1 = a;
        bus.x_read_data2 = b;
        bus.x_reg_write  = 1'b1;
        bus.x_rd         = 5'd8;
        bus.x_reg_dst    = 1'b1;
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stall_cnt;
        int rw_bad;
        stall_cnt = 0;
        rw_bad    = 0;
        rtype(6'h18, a, b);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!bus.stall) break;
            stall_cnt++;
            if (bus.ex_reg_write) rw_bad++;
        end
        check("mult_stall_cycles", stall_cnt, 33);
        check("mult_regwrite_in_stall", rw_bad, 0);
        check("mult_regwrite_done", {31'd0, bus.ex_reg_write}, 32'd0);
        check("mult_hi", bus.hi, exp_hi);
        check("mult_lo", bus.lo, exp_lo);
    endtask

    initial begin
        clear_inputs();
        #12;
        check("rst_alu_result", bus.alu_result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_branch_target", bus.branch_target, 32'd0);
        check("rst_write_reg", {27'd0, bus.write_reg}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // MEM feeds A, WB feeds B
        rtype(6'h20, 32'd99, 32'd77);
        bus.x_rs = 5'd3;  bus.x_rt = 5'd4;
        bus.m_reg_write = 1'b1; bus.m_rd = 5'd3; bus.m_alu_result = 32'd10;
        bus.w_reg_write = 1'b1; bus.w_rd = 5'd4; bus.w_data = 32'd20;
        @(posedge clk); #1;
        check("fwd_priority_sum", bus.alu_result, 32'd30);
        check("fwd_store_data", bus.store_data, 32'd20);
        check("write_reg_rd", {27'd0, bus.write_reg}, 32'd8);
        check("regwrite_pass", {31'd0, bus.ex_reg_write}, 32'd1);

        // Double hazard: MEM wins over WB
        rtype(6'h20, 32'd99, 32'd0);
        bus.x_rs = 5'd5; bus.x_rt = 5'd0;
        bus.m_reg_write = 1'b1; bus.m_rd = 5'd5; bus.m_alu_result = 32'd11;
        bus.w_reg_write = 1'b1; bus.w_rd = 5'd5; bus.w_data = 32'd22;
        @(posedge clk); #1;
        check("double_hazard", bus.alu_result, 32'd11);

        // $0 never forwards
        bus.x_rs = 5'd0; bus.m_rd = 5'd0; bus.w_rd = 5'd0; bus.x_read_data1 = 32'd0;
        @(posedge clk); #1;
        check("reg0_no_fwd", bus.alu_result, 32'd0);
        check("reg0_zero", {31'd0, bus.zero}, 32'd1);

        // beq-style compare and branch target
        @(negedge clk); #1;
        clear_inputs();
        bus.x_alu_op = 2'b01; bus.x_rs = 5'd1; bus.x_rt = 5'd2;
        bus.x_read_data1 = 32'd9; bus.x_read_data2 = 32'd9;
        bus.x_pc_plus4 = 32'h100; bus.x_sign_ext = 32'd3;
        @(posedge clk); #1;
        check("branch_zero", {31'd0, bus.zero}, 32'd1);
        check("branch_target", bus.branch_target, 32'h10C);
        check("write_reg_rt", {27'd0, bus.write_reg}, 32'd2);

        // Sub wraps, then negative offset in the branch target
        bus.x_read_data1 = 32'd5; bus.x_sign_ext = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("sub_wrap", bus.alu_result, 32'hFFFF_FFFC);
        check("branch_target_neg", bus.branch_target, 32'h0000_00FC);

        // addi overrides alu_op and selects the immediate
        bus.x_addi = 1'b1; bus.x_read_data1 = 32'd10; bus.x_sign_ext = 32'hFFFF_FFFE;
        bus.x_mem_read = 1'b1;
        @(posedge clk); #1;
        check("addi_imm", bus.alu_result, 32'd8);
        check("memread_pass", {31'd0, bus.ex_mem_read}, 32'd1);

        bus.x_addi = 1'b0; bus.x_alu_op = 2'b11;
        @(posedge clk); #1;
        check("reserved_op", bus.alu_result, 32'd0);

        rtype(6'h2A, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk); #1;
        check("slt_signed", bus.alu_result, 32'd1);

        rtype(6'h00, 32'd0, 32'd1);
        bus.x_sign_ext = {21'd0, 5'd4, 6'h00};
        @(posedge clk); #1;
        check("sll_4", bus.alu_result, 32'd16);

        rtype(6'h3F, 32'd12, 32'd34);
        @(posedge clk); #1;
        check("bad_funct", bus.alu_result, 32'd0);

        rtype(6'h24, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        @(posedge clk); #1;
        check("and", bus.alu_result, 32'h00F0_000F);
        rtype(6'h25, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        @(posedge clk); #1;
        check("or", bus.alu_result, 32'hFFF0_0FFF);

        // -3 x 7 = -21
        do_mult(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        rtype(6'h12, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("mflo_after_mult", bus.alu_result, 32'hFFFF_FFEB);
        check("mflo_no_stall", {31'd0, bus.stall}, 32'd0);
        rtype(6'h10, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("mfhi_after_mult", bus.alu_result, 32'hFFFF_FFFF);

        // Abort a multiply at count 10
        rtype(6'h18, 32'd5, 32'd6);
        @(posedge clk); #1;
        check("abort_detect_stall", {31'd0, bus.stall}, 32'd1);
        repeat (11) @(negedge clk);
        #2;
        check("abort_busy_stall", {31'd0, bus.stall}, 32'd1);
        rst = 1'b1;
        clear_inputs();
        #1;
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_idle_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_hi_held", bus.hi, 32'd0);

        // Fresh mult after abort proves the FSM is back in IDLE
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        do_mult(32'd65537, 32'd65537, 32'd1, 32'h0002_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
